// File: rtl/ras_pkg.sv
// Shared decode constants and operation type for the return-address-stack pre-decoder.
package ras_pkg;

    localparam logic [6:0] OPC_JAL  = 7'b1101111;
    localparam logic [6:0] OPC_JALR = 7'b1100111;

    // Compressed quadrants and funct3 codes
    localparam logic [1:0] C_Q1     = 2'b01;
    localparam logic [1:0] C_Q2     = 2'b10;
    localparam logic [2:0] C_F3_JAL = 3'b001;
    localparam logic [2:0] C_F3_JR  = 3'b100;

    // Link registers
    localparam logic [4:0] REG_RA = 5'd1;
    localparam logic [4:0] REG_T0 = 5'd5;

    typedef enum logic [1:0] {
        NONE    = 2'd0,
        PUSH    = 2'd1,
        POP     = 2'd2,
        POPPUSH = 2'd3
    } ras_op_e;

    function automatic logic is_link(input logic [4:0] r);
        return (r == REG_RA) || (r == REG_T0);
    endfunction

endpackage

// File: rtl/ras_call_decode.sv
// Combinational classifier of call/return forms in RV32I/RV32C instructions.
module ras_call_decode
    import ras_pkg::*;
#(
    parameter bit RVC = 1'b1
) (
    input  logic [31:0] instr_i,
    output ras_op_e     op_o,
    output logic        is_compressed_o
);

    logic [4:0] rd, rs1, c_rs1, c_rs2;
    logic       is_c;
    logic       unused_hi;

    assign rd        = instr_i[11:7];
    assign rs1       = instr_i[19:15];
    assign c_rs1     = instr_i[11:7];
    assign c_rs2     = instr_i[6:2];
    assign is_c      = RVC && (instr_i[1:0] != 2'b11);
    assign unused_hi = ^instr_i[31:20];

    // Map the instruction onto a stack operation using link-register hints
    always_comb begin
        op_o            = NONE;
        is_compressed_o = is_c;
        if (is_c) begin
            if (instr_i[1:0] == C_Q1 && instr_i[15:13] == C_F3_JAL) begin
                op_o = PUSH;
            end else if (instr_i[1:0] == C_Q2 && instr_i[15:13] == C_F3_JR &&
                         c_rs1 != '0 && c_rs2 == '0) begin
                if (!instr_i[12]) begin
                    op_o = is_link(c_rs1) ? POP : NONE;
                end else begin
                    // C.JALR writes x1, so only an x5 source is a coroutine swap
                    op_o = (c_rs1 == REG_T0) ? POPPUSH : PUSH;
                end
            end
        end else if (instr_i[6:2] == OPC_JAL[6:2]) begin
            op_o = is_link(rd) ? PUSH : NONE;
        end else if (instr_i[6:2] == OPC_JALR[6:2] && instr_i[14:12] == 3'b000) begin
            if (is_link(rd) && is_link(rs1) && rd != rs1) begin
                op_o = POPPUSH;
            end else if (is_link(rd)) begin
                op_o = PUSH;
            end else if (is_link(rs1)) begin
                op_o = POP;
            end
        end
    end

endmodule

// File: rtl/ras_predecode.sv
// Registered pre-decode stage driving a return address stack and tracking
// unresolved speculative stack operations.
module ras_predecode
    import ras_pkg::*;
#(
    parameter int unsigned WIDTH        = 32,
    parameter int unsigned MAX_BRANCHES = 16,
    parameter bit          RVC          = 1'b1
) (
    input  logic                                  clk,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    input  logic                                  fetch_valid_i,
    output logic                                  fetch_ready_o,
    input  logic [WIDTH-1:0]                      fetch_pc_i,
    input  logic [31:0]                           fetch_instr_i,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [WIDTH-1:0]                      out_pc_o,
    output logic [31:0]                           out_instr_o,
    output logic                                  out_is_call_o,
    output logic                                  out_is_ret_o,
    output logic [WIDTH-1:0]                      out_target_o,
    output logic                                  out_target_valid_o,
    output logic                                  ras_push_o,
    output logic                                  ras_pop_o,
    output logic [WIDTH-1:0]                      ras_din_o,
    input  logic [WIDTH-1:0]                      ras_dout_i,
    input  logic                                  ras_valid_i,
    input  logic                                  resolve_i,
    output logic [$clog2(MAX_BRANCHES+1)-1:0]     inflight_o
);

    localparam int unsigned CW = $clog2(MAX_BRANCHES + 1);

    ras_op_e          op;
    logic             is_c, push_dec, pop_dec, acc, inc, dec;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] pc_q, pc_d, tgt_q, tgt_d;
    logic [31:0]      instr_q, instr_d;
    logic             call_q, call_d, ret_q, ret_d, tgtv_q, tgtv_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    ras_call_decode #(.RVC(RVC)) u_decode (
        .instr_i         (fetch_instr_i),
        .op_o            (op),
        .is_compressed_o (is_c)
    );

    assign push_dec = (op == PUSH) || (op == POPPUSH);
    assign pop_dec  = (op == POP)  || (op == POPPUSH);

    assign fetch_ready_o = !flush_i && (cnt_q < CW'(MAX_BRANCHES)) && (!valid_q || out_ready_i);
    assign acc           = fetch_valid_i && fetch_ready_o;
    assign ras_push_o    = acc && push_dec;
    assign ras_pop_o     = acc && pop_dec;
    assign ras_din_o     = fetch_pc_i + (is_c ? WIDTH'(2) : WIDTH'(4));

    assign inc = acc && (push_dec || pop_dec);
    assign dec = resolve_i && (cnt_q != '0);

    // Next-state for the output register and the unresolved-operation counter
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        call_d  = call_q;
        ret_d   = ret_q;
        tgt_d   = tgt_q;
        tgtv_d  = tgtv_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            valid_d = 1'b0;
            cnt_d   = '0;
        end else begin
            if (acc) begin
                valid_d = 1'b1;
                pc_d    = fetch_pc_i;
                instr_d = fetch_instr_i;
                call_d  = push_dec;
                ret_d   = pop_dec;
                tgt_d   = pop_dec ? ras_dout_i : '0;
                tgtv_d  = pop_dec && ras_valid_i;
            end else if (out_ready_i) begin
                valid_d = 1'b0;
            end
            if (inc && !dec) begin
                cnt_d = cnt_q + CW'(1);
            end else if (dec && !inc) begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
            call_q  <= 1'b0;
            ret_q   <= 1'b0;
            tgt_q   <= '0;
            tgtv_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            call_q  <= call_d;
            ret_q   <= ret_d;
            tgt_q   <= tgt_d;
            tgtv_q  <= tgtv_d;
            cnt_q   <= cnt_d;
        end
    end

    assign out_valid_o        = valid_q;
    assign out_pc_o           = pc_q;
    assign out_instr_o        = instr_q;
    assign out_is_call_o      = call_q;
    assign out_is_ret_o       = ret_q;
    assign out_target_o       = tgt_q;
    assign out_target_valid_o = tgtv_q;
    assign inflight_o         = cnt_q;

endmodule
